neighbor_count_engine: RTL
==========================

Name: neighbor_count_engine

Overview:
- Sequential successor to the single-tile combinational neighbour counter.
- On `start`, snapshots the mine map and walks every tile of a rectangular NUM_ROWS x NUM_COLS board, one tile per accepted beat.
- Streams (index, count, is_mine) over a valid/ready write port into the board-state RAM.
- Also produces whole-board totals; supports optional toroidal (wrap-around) neighbourhoods.

Parameters:
- NUM_ROWS, 5, board rows (>= 3; elaboration error otherwise).
- NUM_COLS, 5, board columns (>= 3; elaboration error otherwise).
- NUM_TILES, NUM_ROWS*NUM_COLS, localparam.
- INDEX_LENGTH, $clog2(NUM_TILES), tile index width.
- TOTAL_BITS, $clog2(NUM_TILES+1), width of the total counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin scan; sampled only in IDLE.
- wrap_mode  input  1  1 = toroidal neighbourhood; latched at start.
- mine_map  input  NUM_TILES  bit i = mine at tile i, with i = row*NUM_COLS + col; latched at start.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse after the last tile is accepted.
- wr_valid  output  1  write beat valid.
- wr_ready  input  1  consumer accepts beat.
- wr_index  output  INDEX_LENGTH  tile index of current beat.
- wr_count  output  4  adjacent-mine count, 0..8.
- wr_is_mine  output  1  tile itself is a mine.
- mine_total  output  TOTAL_BITS  mines on the board.
- zero_total  output  TOTAL_BITS  non-mine tiles with count 0 (flood-fill seeds).

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, wr_valid = 0; wr_index, wr_count, wr_is_mine = 0; mine_total, zero_total = 0; snapshot and latched wrap_mode cleared.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN when start=1:
  - Capture mine_map into snapshot register; latch wrap_mode.
  - Pointer index/row/col = 0; clear both totals.
  - busy=1 and wr_valid=1 from the next cycle, i.e. first beat 1 cycle after start.
- SCAN:
  - wr_valid=1. wr_index = pointer. wr_count and wr_is_mine derived only from the snapshot, pointer row/col and latched mode; live mine_map is ignored.
  - Row/col tracked by counters (col wraps to 0 at NUM_COLS-1, row increments); no divider.
  - Beat accepted when wr_valid && wr_ready. On accept:
    - Pointer advances.
    - mine_total += wr_is_mine.
    - zero_total += (!wr_is_mine && wr_count==0).
  - wr_ready=0: pointer, wr_* and totals held stable; no timeout.
  - Accept of tile NUM_TILES-1 -> DONE; wr_valid drops the next cycle.
- DONE: lasts one cycle. done=1, busy=0, wr_valid=0, then -> IDLE. Minimum scan length is NUM_TILES+2 cycles from start to done.
- Totals hold their final values after done until the next accepted start.
- start is ignored in SCAN and DONE. A start in the same cycle as done is ignored; it must be re-asserted in IDLE.
- Neighbourhood is the 8 surrounding tiles; the tile itself is never counted.
  - wrap_mode=0: off-board neighbours are skipped (corner max 3, edge max 5, interior max 8).
  - wrap_mode=1: row-1 of 0 maps to NUM_ROWS-1 and row+1 of NUM_ROWS-1 maps to 0; same for columns. Every tile has exactly 8 distinct neighbours (guaranteed by the >=3 constraint).
- wr_count is 4 bits and never exceeds 8; totals cannot overflow by construction.
- Reset asserted mid-scan: immediate return to IDLE, all outputs at reset values, partial totals discarded, no done pulse.

Test Plan:
- 5x5, wrap=0, single mine at 12, wr_ready=1: 25 beats, indices 0..24 in order. Tiles 6,7,8,11,13,16,17,18 count 1; tile 12 is_mine=1, count 0; others 0. mine_total=1, zero_total=16. done pulses exactly once, 27 cycles after start.
- 5x5, mine at 0 only: wrap=0 gives tile 24 count 0 and zero_total=21. wrap=1 gives tiles 24, 4, 20 count 1 and zero_total=16.
- 5x5 all mines, wrap=0: corners count 3, edges 5, interior 8, all is_mine=1. mine_total=25, zero_total=0. With wrap=1 every count is 8.
- Backpressure: wr_ready toggles 1,0,0,1,... All wr_* hold while ready=0, no index skipped or duplicated, totals match the ready=1 run. Changing mine_map mid-scan has no effect.
- start pulsed during SCAN and in the same cycle as done: ignored, single scan. rst raised at beat 10: outputs zero asynchronously, no done; a later start rescans from index 0.
- NUM_ROWS=4, NUM_COLS=6, wrap=0, mine at 23: 24 beats. Tiles 16,17,22 count 1; zero_total=20.

Source files
------------

// File: rtl/neighbor_count_engine.sv
// neighbor_count_engine: scans a snapshotted mine map tile by tile, streaming per-tile neighbour counts and board totals
module neighbor_count_engine #(
    parameter int NUM_ROWS = 5,
    parameter int NUM_COLS = 5,
    localparam int NUM_TILES = NUM_ROWS * NUM_COLS,
    localparam int INDEX_LENGTH = $clog2(NUM_TILES),
    localparam int TOTAL_BITS = $clog2(NUM_TILES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wrap_mode,
    input  logic [NUM_TILES-1:0]    mine_map,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [INDEX_LENGTH-1:0] wr_index,
    output logic [3:0]              wr_count,
    output logic                    wr_is_mine,
    output logic [TOTAL_BITS-1:0]   mine_total,
    output logic [TOTAL_BITS-1:0]   zero_total
);
    localparam int RB = $clog2(NUM_ROWS);
    localparam int CB = $clog2(NUM_COLS);

    if (NUM_ROWS < 3 || NUM_COLS < 3) begin : g_bad_size
        $error("neighbor_count_engine: NUM_ROWS and NUM_COLS must both be >= 3");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state, state_d;
    logic [NUM_TILES-1:0]    snap;
    logic                    wrap_q;
    logic [INDEX_LENGTH-1:0] idx;
    logic [RB-1:0]           row;
    logic [CB-1:0]           col;
    logic [3:0]              nbr;
    logic                    accept, last;

    assign accept = wr_valid && wr_ready;
    assign last   = idx == INDEX_LENGTH'(NUM_TILES - 1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // next state and status outputs; start only matters in IDLE
    always_comb begin
        state_d  = (state == IDLE && start)          ? SCAN :
                   (state == SCAN && accept && last) ? DONE :
                   (state == DONE)                   ? IDLE : state;
        busy     = state == SCAN;
        done     = state == DONE;
        wr_valid = state == SCAN;
    end

    // snapshot, tile pointer (row/col counters avoid a divider) and running totals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap       <= '0;
            wrap_q     <= 1'b0;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            mine_total <= '0;
            zero_total <= '0;
        end else if (state == IDLE && start) begin
            snap       <= mine_map;
            wrap_q     <= wrap_mode;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            mine_total <= '0;
            zero_total <= '0;
        end else if (accept) begin
            idx        <= last ? '0 : idx + INDEX_LENGTH'(1);
            col        <= (col == CB'(NUM_COLS - 1)) ? '0 : col + CB'(1);
            row        <= (col != CB'(NUM_COLS - 1)) ? row :
                          (row == RB'(NUM_ROWS - 1)) ? '0 : row + RB'(1);
            mine_total <= mine_total + TOTAL_BITS'(wr_is_mine);
            zero_total <= zero_total + TOTAL_BITS'(!wr_is_mine && wr_count == 4'd0);
        end
    end

    // count mines among the 8 neighbours; off-board ones are dropped or wrapped by the latched mode
    always_comb begin
        int  r, c, n;
        logic ok;
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r  = int'(row) + dr;
                c  = int'(col) + dc;
                ok = (dr != 0) || (dc != 0);
                if (r < 0) begin
                    r  = NUM_ROWS - 1;
                    ok = ok && wrap_q;
                end else if (r >= NUM_ROWS) begin
                    r  = 0;
                    ok = ok && wrap_q;
                end
                if (c < 0) begin
                    c  = NUM_COLS - 1;
                    ok = ok && wrap_q;
                end else if (c >= NUM_COLS) begin
                    c  = 0;
                    ok = ok && wrap_q;
                end
                n = r * NUM_COLS + c;
                if (ok && snap[n[INDEX_LENGTH-1:0]]) nbr = nbr + 4'd1;
            end
        end
    end

    assign wr_index   = busy ? idx : '0;
    assign wr_count   = busy ? nbr : '0;
    assign wr_is_mine = busy && snap[idx];
endmodule
